tx_framer: RTL and testbench

Transmit-side packet framer that sits directly upstream of the RF output path. It accepts payload bytes over a valid/ready handshake and serialises a complete OOK frame MSB-first on `tx_out`: preamble, then sync word, then payload, then an optional CRC-8. Each bit is held for a programmable number of clock cycles. `tx_out` is intended to be ORed into the transmitter output alongside the bypass input.

---
 rtl/tx_framer.sv | 241 ++++++++++++++++++++++++
 tb/tb_tx_framer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_framer.sv
// OOK transmit framer: preamble, sync word, payload bytes and optional CRC-8, MSB-first.
// Define TX_FRAMER_CRC_EN to append a CRC-8 (poly 0x07, init 0x00) after the payload.
module tx_framer #(
    parameter int         PAYLOAD_BYTES = 3,
    parameter int         PREAMBLE_BITS = 8,
    parameter logic [7:0] SYNC_WORD     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] bit_period,
    input  logic        start,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        tx_out,
    output logic        busy,
    output logic        done,
    output logic        underrun
);
    localparam logic [4:0] NBYTES   = 5'(PAYLOAD_BYTES);
    localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SYNC,
        ST_PAYLOAD
`ifdef TX_FRAMER_CRC_EN
        , ST_CRC
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] period_q, period_d;
    logic [13:0] timer_q, timer_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [4:0]  fetch_cnt_q, fetch_cnt_d;
    logic [4:0]  sent_cnt_q, sent_cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_out_q, tx_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        underrun_q, underrun_d;
    logic        byte_ready_q, byte_ready_d;
`ifdef TX_FRAMER_CRC_EN
    logic [7:0]  crc_q, crc_d;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    logic accept;
    logic shift_out;
    logic next_byte;
    logic finish;

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        fetch_cnt_d  = fetch_cnt_q;
        sent_cnt_d   = sent_cnt_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        tx_out_d     = tx_out_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        underrun_d   = 1'b0;
        byte_ready_d = byte_ready_q;
`ifdef TX_FRAMER_CRC_EN
        crc_d        = crc_q;
`endif
        shift_out    = 1'b0;
        next_byte    = 1'b0;
        finish       = 1'b0;

        // byte_ready_q is only ever high while the holding register is empty
        accept = byte_valid & byte_ready_q;
        if (accept) begin
            hold_d      = byte_data;
            hold_full_d = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 5'd1;
        end

        if (state_q == ST_IDLE) begin
            tx_out_d = 1'b0;
            if (start) begin
                state_d    = ST_PREAMBLE;
                period_d   = bit_period;
                timer_d    = bit_period;
                bit_cnt_d  = 6'd0;
                sent_cnt_d = 5'd0;
                tx_out_d   = 1'b1;
                busy_d     = 1'b1;
`ifdef TX_FRAMER_CRC_EN
                crc_d      = 8'h00;
`endif
            end
        end else if (timer_q != 14'd0) begin
            timer_d = timer_q - 14'd1;
        end else begin
            // bit_tick: decide the next bit so it appears on the following cycle
            timer_d   = period_q;
            bit_cnt_d = bit_cnt_q + 6'd1;
            case (state_q)
                ST_PREAMBLE: begin
                    if (bit_cnt_q == PRE_LAST) begin
                        state_d   = ST_SYNC;
                        bit_cnt_d = 6'd0;
                        tx_out_d  = SYNC_WORD[7];
                        shift_d   = {SYNC_WORD[6:0], 1'b0};
                    end else begin
                        tx_out_d = bit_cnt_q[0];
                    end
                end
                ST_SYNC: begin
                    if (bit_cnt_q == 6'd7) next_byte = 1'b1;
                    else                   shift_out = 1'b1;
                end
                ST_PAYLOAD: begin
                    if (bit_cnt_q == 6'd7) begin
                        if (sent_cnt_q == NBYTES) begin
`ifdef TX_FRAMER_CRC_EN
                            state_d   = ST_CRC;
                            bit_cnt_d = 6'd0;
                            tx_out_d  = crc_q[7];
                            shift_d   = {crc_q[6:0], 1'b0};
`else
                            finish = 1'b1;
`endif
                        end else begin
                            next_byte = 1'b1;
                        end
                    end else begin
                        shift_out = 1'b1;
                    end
                end
`ifdef TX_FRAMER_CRC_EN
                ST_CRC: begin
                    if (bit_cnt_q == 6'd7) finish = 1'b1;
                    else                   shift_out = 1'b1;
                end
`endif
                default: ;
            endcase
        end

        if (shift_out) begin
            tx_out_d = shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
        end

        if (next_byte) begin
            bit_cnt_d = 6'd0;
            if (hold_full_q) begin
                state_d     = ST_PAYLOAD;
                tx_out_d    = hold_q[7];
                shift_d     = {hold_q[6:0], 1'b0};
                hold_full_d = 1'b0;
                sent_cnt_d  = sent_cnt_q + 5'd1;
`ifdef TX_FRAMER_CRC_EN
                crc_d       = crc8_byte(crc_q, hold_q);
`endif
            end else begin
                // A byte arriving in this very cycle stays for the next frame
                state_d     = ST_IDLE;
                tx_out_d    = 1'b0;
                busy_d      = 1'b0;
                underrun_d  = 1'b1;
                fetch_cnt_d = {4'd0, accept};
            end
        end

        if (finish) begin
            state_d     = ST_IDLE;
            tx_out_d    = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            fetch_cnt_d = {4'd0, accept};
        end

        byte_ready_d = ~hold_full_d & (fetch_cnt_d < NBYTES);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            period_q     <= 14'd0;
            timer_q      <= 14'd0;
            bit_cnt_q    <= 6'd0;
            fetch_cnt_q  <= 5'd0;
            sent_cnt_q   <= 5'd0;
            hold_q       <= 8'h00;
            hold_full_q  <= 1'b0;
            shift_q      <= 8'h00;
            tx_out_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
            byte_ready_q <= 1'b0;
`ifdef TX_FRAMER_CRC_EN
            crc_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            fetch_cnt_q  <= fetch_cnt_d;
            sent_cnt_q   <= sent_cnt_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            tx_out_q     <= tx_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
            byte_ready_q <= byte_ready_d;
`ifdef TX_FRAMER_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign tx_out     = tx_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_tx_framer.sv
// Scoreboard bench for tx_framer: expected per-cycle outputs are queued at frame start
// and popped by an independent monitor; a random-gap byte source feeds the payload.
`timescale 1ns/1ps
module tb_tx_framer;
    localparam int         PB   = 3;
    localparam int         PRE  = 8;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] bit_period = 14'd0;
    logic        start = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        tx_out;
    logic        busy;
    logic        done;
    logic        underrun;

    always #5 clk = ~clk;

    tx_framer #(
        .PAYLOAD_BYTES(PB),
        .PREAMBLE_BITS(PRE),
        .SYNC_WORD(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bit_period(bit_period),
        .start(start),
        .byte_data(byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx_out(tx_out),
        .busy(busy),
        .done(done),
        .underrun(underrun)
    );

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
        logic underrun;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[$];
    logic [7:0] pay[PB];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         frame_no = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one expected record per cycle, idle outputs when nothing is queued
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_t e;
                exp_t a;
                e = '0;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                a = exp_t'({tx_out, busy, done, underrun});
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs at cycle %0d {tx,busy,done,underrun}: got %b expected %b",
                             cyc, a, e);
                end
            end
        end
    end

    // Byte source: presents queued bytes with at most two idle cycles in a row
    initial begin
        int   gap;
        logic hs;
        gap = 0;
        forever begin
            @(negedge clk);
            hs = byte_valid && byte_ready && rst;
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0) src_q.delete(0);
            if (!rst) begin
                byte_valid = 1'b0;
                gap = 0;
            end else if (src_q.size() > 0 && (gap >= 2 || $urandom_range(0, 2) != 0)) begin
                byte_valid = 1'b1;
                byte_data  = src_q[0];
                gap = 0;
            end else begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                if (src_q.size() > 0) gap++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_queue(input int left);
        int n;
        n = 0;
        while (exp_q.size() > left && n < 20000) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != left) begin
            errors++;
            $display("FAIL frame drain: got %0d records pending expected %0d", exp_q.size(), left);
        end
    endtask

    // Reference model: frame as a list of bits, each widened to p+1 cycles
    task automatic start_frame(input int p, input int nsup, input bit b2b);
        bit         bits[$];
        logic [7:0] crc;
        logic       fb;
        exp_t       e;
        if (b2b) begin
            wait_queue(1);
            for (int j = 0; j < nsup; j++) src_q.push_back(pay[j]);
        end else begin
            wait_queue(0);
            for (int j = 0; j < nsup; j++) src_q.push_back(pay[j]);
            repeat (6) step();
        end
        for (int k = 0; k < PRE; k++) bits.push_back(k % 2 == 0);
        for (int i = 7; i >= 0; i--) bits.push_back(SYNC[i]);
        crc = 8'h00;
        for (int j = 0; j < PB && j < nsup; j++) begin
            for (int i = 7; i >= 0; i--) begin
                bits.push_back(pay[j][i]);
                fb  = crc[7] ^ pay[j][i];
                crc = {crc[6:0], 1'b0};
                if (fb) crc = crc ^ 8'h07;
            end
        end
`ifdef TX_FRAMER_CRC_EN
        if (nsup >= PB) begin
            for (int i = 7; i >= 0; i--) bits.push_back(crc[i]);
        end
`endif
        if (exp_q.size() == 0) exp_q.push_back('0);
        foreach (bits[k]) begin
            e = '0;
            e.tx   = bits[k];
            e.busy = 1'b1;
            repeat (p + 1) exp_q.push_back(e);
        end
        e = '0;
        if (nsup >= PB) e.done = 1'b1;
        else            e.underrun = 1'b1;
        exp_q.push_back(e);
        frame_no++;
        $display("frame %0d: period=%0d bytes_supplied=%0d bits=%0d end_cycle_offset=%0d crc=%02h",
                 frame_no, p, nsup, bits.size(), 1 + bits.size() * (p + 1), crc);
        start      = 1'b1;
        bit_period = 14'(p);
        step();
        start = 1'b0;
    endtask

    task automatic rand_payload();
        for (int j = 0; j < PB; j++) pay[j] = 8'($urandom);
    endtask

    initial begin
        #23;
        checks++;
        if ({tx_out, busy, done, underrun, byte_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset outputs {tx,busy,done,underrun,ready}: got %b expected 00000",
                     {tx_out, busy, done, underrun, byte_ready});
        end
        step();
        rst = 1'b1;
        step();

        // Known payload, 4 cycles per bit
        pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'h56;
        start_frame(3, 3, 1'b0);

        // Single-cycle bits; with CRC enabled the tail is 0x6B
        pay[0] = 8'h01; pay[1] = 8'h00; pay[2] = 8'h00;
        start_frame(0, 3, 1'b0);

        // Underrun at the second byte boundary
        pay[0] = 8'h12;
        start_frame(1, 1, 1'b0);

        rand_payload();
        start_frame(2, 3, 1'b0);

        // start and bit_period disturbed mid-frame
        rand_payload();
        start_frame(3, 3, 1'b0);
        repeat (20) step();
        start = 1'b1;
        bit_period = 14'd7;
        step();
        start = 1'b0;
        repeat (60) step();
        start = 1'b1;
        step();
        start = 1'b0;

        // Reset asserted during the sync word
        rand_payload();
        start_frame(3, 3, 1'b0);
        repeat (8 * 4 + 3 * 4) step();
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        src_q.delete();
        #1;
        checks++;
        if ({tx_out, busy, done, underrun, byte_ready} !== 5'b0) begin
            errors++;
            $display("FAIL mid-frame reset {tx,busy,done,underrun,ready}: got %b expected 00000",
                     {tx_out, busy, done, underrun, byte_ready});
        end
        repeat (3) step();
        rst = 1'b1;
        step();
        rand_payload();
        start_frame(2, 3, 1'b0);

        // Back-to-back frames, start in the done cycle
        for (int f = 0; f < 3; f++) begin
            rand_payload();
            start_frame($urandom_range(0, 4), 3, 1'b1);
        end

        for (int f = 0; f < 4; f++) begin
            rand_payload();
            start_frame($urandom_range(0, 5), 3, 1'b0);
        end

        wait_queue(0);
        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
